// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the MEM-stage load/store sequencer.
//   mem_size_t  : access size encoding (byte, half, word, doubleword)
//   lsu_state_t : sequencer FSM states
//   size_mask   : right-aligned byte-enable base for a size
//   misaligned  : natural-alignment check for a size and byte offset
//   lane_mask   : expands 8 byte enables into a 64-bit bit mask
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_t;

    function automatic logic [7:0] size_mask(input mem_size_t size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned(input mem_size_t size, input logic [2:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    function automatic logic [63:0] lane_mask(input logic [7:0] be);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane alignment for a 64-bit doubleword port (combinational).
//   EXTRACT=0 : store path, shifts right-aligned data up into its lanes
//   EXTRACT=1 : load path, shifts lane data down and zero-extends
// Ports:
//   size     : access size
//   off      : byte offset within the doubleword
//   data_in  : store operand (EXTRACT=0) or raw read data (EXTRACT=1)
//   be       : byte enables for the access
//   data_out : lane-placed store data or zero-extended load data
module lane_align
    import cpu_mem_pkg::*;
#(
    parameter bit EXTRACT = 1'b0
) (
    input  mem_size_t   size,
    input  logic [2:0]  off,
    input  logic [63:0] data_in,
    output logic [7:0]  be,
    output logic [63:0] data_out
);

    logic [7:0] base;
    logic [5:0] shamt;

    always_comb begin
        base  = size_mask(size);
        shamt = {off, 3'b000};
        be    = base << off;
        // Masking after the shift clears every bit outside the active lanes.
        if (EXTRACT) begin
            data_out = (data_in >> shamt) & lane_mask(base);
        end else begin
            data_out = (data_in << shamt) & lane_mask(be);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer. Accepts one load or store from the
// pipeline, runs it on a request/acknowledge doubleword memory port and
// stalls the pipeline until the access retires.
// Ports:
//   clk, reset            : clock (rising edge), async active-low reset
//   op_valid/load/store   : memory instruction present, read or write
//   op_size, addr         : access size and effective address
//   store_data            : right-aligned store operand
//   mem_req/we/addr/wdata/be, mem_ack/rdata : data-memory handshake port
//   stall                 : freeze upstream pipeline registers
//   load_data             : zero-extended load result
//   done                  : one-cycle pulse when an access retires
//   err                   : one-cycle pulse on misalignment, bad op or timeout
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_load,
    input  logic              op_store,
    input  logic [1:0]        op_size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    lsu_state_t        state_q, state_d;
    mem_size_t         size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic [DATA_W-1:0] load_q;

    logic              accept;
    logic              flag_err;
    logic              ack_take;

    logic [7:0]        wr_be;
    logic [DATA_W-1:0] wr_data;
    logic [7:0]        rd_be_unused;
    logic [DATA_W-1:0] rd_data;

    // Both lane paths work from the registered copies, so the memory port
    // stays stable while the pipeline inputs are don't-care under stall.
    lane_align #(.EXTRACT(1'b0)) u_wr_align (
        .size     (size_q),
        .off      (addr_q[2:0]),
        .data_in  (store_q),
        .be       (wr_be),
        .data_out (wr_data)
    );

    lane_align #(.EXTRACT(1'b1)) u_rd_align (
        .size     (size_q),
        .off      (addr_q[2:0]),
        .data_in  (mem_rdata),
        .be       (rd_be_unused),
        .data_out (rd_data)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can leave a latch behind.
        state_d  = state_q;
        accept   = 1'b0;
        flag_err = 1'b0;
        ack_take = 1'b0;
        mem_req  = 1'b0;
        stall    = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_valid && (op_load ^ op_store)) begin
                    if (misaligned(mem_size_t'(op_size), addr[2:0])) begin
                        flag_err = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = REQ;
                    end
                end else if (op_valid && op_load && op_store) begin
                    flag_err = 1'b1;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_ack) begin
                    ack_take = 1'b1;
                    state_d  = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_ack) begin
                    ack_take = 1'b1;
                    state_d  = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    flag_err = 1'b1;
                    state_d  = IDLE;
                end
            end
            DONE: begin
                // The pipeline advances here; anything it presents is dropped.
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            size_q  <= SZ_B;
            addr_q  <= '0;
            store_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            err_q   <= flag_err;
            if (accept) begin
                addr_q  <= addr;
                size_q  <= mem_size_t'(op_size);
                store_q <= store_data;
                we_q    <= op_store;
                cnt_q   <= '0;
            end else if (state_q == WAIT && !mem_ack) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (ack_take && !we_q) begin
                load_q <= rd_data;
            end
        end
    end

    // Port fields read as zero whenever no request is outstanding.
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign mem_be    = mem_req ? wr_be : 8'h00;
    assign mem_wdata = mem_req ? wr_data : '0;
    assign load_data = load_q;
    assign err       = err_q;

endmodule
